yarp_alu_arb: RTL and testbench

Shares the single-cycle ALU (yarp_execute) between NUM_REQ requesters, e.g. the main pipeline and a load/store address generator or debug unit. Round-robin arbitration with a valid/ready handshake on every port. The result is registered and returned only to the granted requester, with backpressure. Sits in front of the execute stage; the ALU itself is unchanged.

---
 rtl/yarp_pkg.sv | 26 ++
 rtl/yarp_execute.sv | 33 +++
 rtl/yarp_rr_arb.sv | 51 +++++
 rtl/yarp_alu_arb.sv | 87 ++++++++
 tb/tb_yarp_alu_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/yarp_pkg.sv
// Shared YARP types: ALU opcodes, the request bundle used by the ALU arbiter,
// and the default requester count.
package yarp_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLL  = 4'd2,
      OP_SRL  = 4'd3,
      OP_SRA  = 4'd4,
      OP_OR   = 4'd5,
      OP_AND  = 4'd6,
      OP_XOR  = 4'd7,
      OP_SLTU = 4'd8,
      OP_SLT  = 4'd9
   } alu_op_e;

   typedef struct packed {
      logic [31:0] opr_a;
      logic [31:0] opr_b;
      alu_op_e     op_sel;
   } alu_req_t;

   localparam int ALU_ARB_NUM_REQ = 2;

endpackage

// File: rtl/yarp_execute.sv
// Single-cycle combinational ALU. Unlisted opcodes return zero; shifts use
// the low five bits of operand B.
module yarp_execute
   import yarp_pkg::*;
(
   input  logic [31:0] opr_a_i,
   input  logic [31:0] opr_b_i,
   input  alu_op_e     op_sel_i,
   output logic [31:0] alu_res_o
);

   logic [4:0] shamt;

   assign shamt = opr_b_i[4:0];

   always_comb begin
      alu_res_o = 32'h0;
      case (op_sel_i)
         OP_ADD:  alu_res_o = opr_a_i + opr_b_i;
         OP_SUB:  alu_res_o = opr_a_i - opr_b_i;
         OP_SLL:  alu_res_o = opr_a_i << shamt;
         OP_SRL:  alu_res_o = opr_a_i >> shamt;
         OP_SRA:  alu_res_o = $unsigned($signed(opr_a_i) >>> shamt);
         OP_OR:   alu_res_o = opr_a_i | opr_b_i;
         OP_AND:  alu_res_o = opr_a_i & opr_b_i;
         OP_XOR:  alu_res_o = opr_a_i ^ opr_b_i;
         OP_SLTU: alu_res_o = {31'h0, (opr_a_i < opr_b_i)};
         OP_SLT:  alu_res_o = {31'h0, ($signed(opr_a_i) < $signed(opr_b_i))};
         default: alu_res_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/yarp_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping; the pointer moves past the winner only when the grant is taken.
module yarp_rr_arb #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               adv,
   output logic [NUM_REQ-1:0] gnt_oh,
   output logic [ID_W-1:0]    gnt_idx,
   output logic               gnt_vld
);

   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] ptr_d;
   logic [ID_W-1:0] cand;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= int'(NUM_REQ)) s = s - int'(NUM_REQ);
      return ID_W'(s);
   endfunction

   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = wrap_add(ptr_q, i);
         if (!gnt_vld && req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt_oh = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
      ptr_d  = wrap_add(gnt_idx, 1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (adv && gnt_vld) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/yarp_alu_arb.sv
// Shares one yarp_execute ALU among NUM_REQ requesters with round-robin
// grant and a one-entry registered result returned to the granted requester.
module yarp_alu_arb
   import yarp_pkg::*;
#(
   parameter int NUM_REQ = ALU_ARB_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   input  logic [NUM_REQ-1:0][31:0] req_opr_a_i,
   input  logic [NUM_REQ-1:0][31:0] req_opr_b_i,
   input  alu_op_e [NUM_REQ-1:0]   req_op_sel_i,
   output logic [NUM_REQ-1:0]      rsp_valid_o,
   input  logic [NUM_REQ-1:0]      rsp_ready_i,
   output logic [31:0]             rsp_data_o
);

   logic [NUM_REQ-1:0] gnt_oh;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_vld;
   logic               can_accept;
   logic               accept;
   alu_req_t           gnt_req;
   logic [31:0]        alu_res;

   logic [31:0]        res_q;
   logic [ID_W-1:0]    own_q;
   logic               full_q;

   yarp_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid_i),
      .adv     (accept),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign gnt_req = '{opr_a:  req_opr_a_i[gnt_idx],
                      opr_b:  req_opr_b_i[gnt_idx],
                      op_sel: req_op_sel_i[gnt_idx]};

   yarp_execute u_execute (
      .opr_a_i   (gnt_req.opr_a),
      .opr_b_i   (gnt_req.opr_b),
      .op_sel_i  (gnt_req.op_sel),
      .alu_res_o (alu_res)
   );

   // The owner draining in this same cycle frees the slot, so
   // rsp_ready_i reaches req_ready_o combinationally.
   assign can_accept  = !full_q || rsp_ready_i[own_q];
   assign req_ready_o = (can_accept && gnt_vld && !reset) ? gnt_oh : '0;
   assign accept      = |req_ready_o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q  <= 32'h0;
         own_q  <= '0;
         full_q <= 1'b0;
      end else if (accept) begin
         res_q  <= alu_res;
         own_q  <= gnt_idx;
         full_q <= 1'b1;
      end else if (full_q && rsp_ready_i[own_q]) begin
         full_q <= 1'b0;
      end
   end

   assign rsp_valid_o = full_q ? (NUM_REQ'(1) << own_q) : '0;
   assign rsp_data_o  = res_q;

   a_rsp_onehot : assert property (@(posedge clk) disable iff (reset)
      $onehot0(rsp_valid_o));
   a_req_onehot : assert property (@(posedge clk) disable iff (reset)
      $onehot0(req_ready_o));
   a_hold : assert property (@(posedge clk) disable iff (reset)
      (full_q && !rsp_ready_i[own_q]) |=> ($stable(res_q) && $stable(own_q) && full_q));

endmodule

// File: tb/tb_yarp_alu_arb.sv
// Scenario bench for yarp_alu_arb: accepted requests push a model result,
// delivered responses pop and compare; scenario tasks check timing inline.
module tb_yarp_alu_arb;
   import yarp_pkg::*;

   logic              clk;
   logic              reset;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0][31:0]  opr_a;
   logic [1:0][31:0]  opr_b;
   alu_op_e [1:0]     op_sel;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [31:0]       rsp_data;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } sb_t;

   sb_t sb[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   yarp_alu_arb #(.NUM_REQ(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_opr_a_i  (opr_a),
      .req_opr_b_i  (opr_b),
      .req_op_sel_i (op_sel),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_data_o   (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a << sh;
         4'd3: return a >> sh;
         4'd4: return $unsigned($signed(a) >>> sh);
         4'd5: return a | b;
         4'd6: return a & b;
         4'd7: return a ^ b;
         4'd8: return (a < b) ? 32'd1 : 32'd0;
         4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'h0;
      endcase
   endfunction

   // Scoreboard: runs on the falling edge, when inputs and outputs are settled.
   always @(negedge clk) begin
      sb_t e;
      if (reset) begin
         sb.delete();
      end else begin
         if ((rsp_valid & rsp_ready) != 2'b00) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_underflow: rsp_valid=%b data=%h, none expected", rsp_valid, rsp_data);
            end else begin
               e = sb.pop_front();
               if (rsp_valid !== (2'b01 << e.idx) || rsp_data !== e.data) begin
                  n_fail++;
                  $display("FAIL sb_rsp: got valid=%b data=%h, want valid=%b data=%h",
                           rsp_valid, rsp_data, 2'b01 << e.idx, e.data);
               end
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (req_ready[i] && req_valid[i])
               sb.push_back('{idx: i, data: alu_model(opr_a[i], opr_b[i], op_sel[i])});
         end
      end
   end

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input alu_op_e op);
      opr_a[i]  = a;
      opr_b[i]  = b;
      op_sel[i] = op;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      set_req(0, 32'd1, 32'd2, OP_ADD);
      set_req(1, 32'd3, 32'd4, OP_ADD);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      n_checks++;
      if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rsp: valid=%b data=%h, want 00/00000000", rsp_valid, rsp_data);
      end
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 00", req_ready);
      end
      @(posedge clk); #2;
      reset = 1'b0;
      req_valid = 2'b00;
   endtask

   task automatic test_single_add();
      @(posedge clk); #2;
      set_req(0, 32'd5, 32'd7, OP_ADD);
      req_valid = 2'b01;
      rsp_ready = 2'b11;
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL add_ready: got %b want 01", req_ready);
      end
      @(posedge clk); #2;
      req_valid = 2'b00;
      @(negedge clk); #1;
      n_checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 32'h0000000C) begin
         n_fail++;
         $display("FAIL add_rsp: valid=%b data=%h, want 01/0000000c", rsp_valid, rsp_data);
      end
   endtask

   task automatic test_two_requesters();
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      set_req(0, 32'd3, 32'd5, OP_SUB);
      set_req(1, 32'hFFFFFFFF, 32'd1, OP_SLT);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL two_grant0: got %b want 01", req_ready);
      end
      @(posedge clk); #2;
      req_valid = 2'b10;
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 2'b10 || rsp_valid !== 2'b01 || rsp_data !== 32'hFFFFFFFE) begin
         n_fail++;
         $display("FAIL two_cyc1: ready=%b valid=%b data=%h, want 10/01/fffffffe",
                  req_ready, rsp_valid, rsp_data);
      end
      @(posedge clk); #2;
      req_valid = 2'b00;
      @(negedge clk); #1;
      n_checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'h00000001) begin
         n_fail++;
         $display("FAIL two_cyc2: valid=%b data=%h, want 10/00000001", rsp_valid, rsp_data);
      end
   endtask

   task automatic test_backpressure();
      @(posedge clk); #2;
      set_req(0, 32'd1, 32'd2, OP_ADD);
      req_valid = 2'b01;
      rsp_ready = 2'b00;
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_accept: got %b want 01", req_ready);
      end
      @(posedge clk); #2;
      set_req(1, 32'h0F0F0F0F, 32'hFFFF0000, OP_XOR);
      req_valid = 2'b10;
      rsp_ready = 2'b10;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         n_checks++;
         if (req_ready !== 2'b00 || rsp_valid !== 2'b01 || rsp_data !== 32'd3) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: ready=%b valid=%b data=%h, want 00/01/00000003",
                     k, req_ready, rsp_valid, rsp_data);
         end
         @(posedge clk); #2;
      end
      rsp_ready = 2'b01;
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_refill: got %b want 10", req_ready);
      end
      @(posedge clk); #2;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      @(negedge clk); #1;
      n_checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'hF0F00F0F) begin
         n_fail++;
         $display("FAIL bp_rsp1: valid=%b data=%h, want 10/f0f00f0f", rsp_valid, rsp_data);
      end
   endtask

   task automatic test_fairness();
      logic [1:0] took;
      @(posedge clk); #2;
      for (int i = 0; i < 2; i++)
         set_req(i, $urandom, $urandom, alu_op_e'($urandom_range(0, 9)));
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         n_checks++;
         if (req_ready !== (2'b01 << (k % 2))) begin
            n_fail++;
            $display("FAIL fair_grant[%0d]: got %b want %b", k, req_ready, 2'b01 << (k % 2));
         end
         if (k > 0) begin
            n_checks++;
            if (rsp_valid !== (2'b01 << ((k - 1) % 2))) begin
               n_fail++;
               $display("FAIL fair_rsp[%0d]: got %b want %b", k, rsp_valid, 2'b01 << ((k - 1) % 2));
            end
         end
         took = req_ready;
         @(posedge clk); #2;
         for (int i = 0; i < 2; i++)
            if (took[i]) set_req(i, $urandom, $urandom, alu_op_e'($urandom_range(0, 9)));
         if (k == 7) req_valid = 2'b00;
      end
      @(negedge clk); #1;
      n_checks++;
      if (rsp_valid !== 2'b10) begin
         n_fail++;
         $display("FAIL fair_last: got %b want 10", rsp_valid);
      end
   endtask

   task automatic test_shifts_illegal();
      @(posedge clk); #2;
      set_req(1, 32'h80000000, 32'd4, OP_SRA);
      req_valid = 2'b10;
      rsp_ready = 2'b11;
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL sra_ready: got %b want 10", req_ready);
      end
      @(posedge clk); #2;
      set_req(1, 32'd1, 32'd33, OP_SLL);
      @(negedge clk); #1;
      n_checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'hF8000000 || req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL sra_rsp: valid=%b data=%h ready=%b, want 10/f8000000/10",
                  rsp_valid, rsp_data, req_ready);
      end
      @(posedge clk); #2;
      set_req(0, 32'd123, 32'd456, alu_op_e'(4'd13));
      req_valid = 2'b01;
      @(negedge clk); #1;
      n_checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'h00000002) begin
         n_fail++;
         $display("FAIL sll_rsp: valid=%b data=%h, want 10/00000002", rsp_valid, rsp_data);
      end
      @(posedge clk); #2;
      req_valid = 2'b00;
      @(negedge clk); #1;
      n_checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 32'h0) begin
         n_fail++;
         $display("FAIL illegal_rsp: valid=%b data=%h, want 01/00000000", rsp_valid, rsp_data);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #2;
      set_req(1, 32'd1, 32'd1, OP_ADD);
      req_valid = 2'b10;
      rsp_ready = 2'b00;
      @(posedge clk); #1;
      req_valid = 2'b00;
      n_checks++;
      if (rsp_valid !== 2'b10) begin
         n_fail++;
         $display("FAIL ar_pending: got %b want 10", rsp_valid);
      end
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
         n_fail++;
         $display("FAIL ar_drop: valid=%b data=%h, want 00/00000000", rsp_valid, rsp_data);
      end
      set_req(0, 32'h000000F0, 32'h0000000F, OP_OR);
      set_req(1, 32'd10, 32'd20, OP_SLTU);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL ar_ptr0: got %b want 01", req_ready);
      end
      @(posedge clk); #2;
      req_valid = 2'b10;
      @(negedge clk); #1;
      n_checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 32'h000000FF) begin
         n_fail++;
         $display("FAIL ar_rsp0: valid=%b data=%h, want 01/000000ff", rsp_valid, rsp_data);
      end
      @(posedge clk); #2;
      set_req(0, 32'd9, 32'd4, OP_SRL);
      req_valid = 2'b01;
      @(posedge clk); #2;
      req_valid = 2'b00;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      req_valid = 2'b11;
      @(negedge clk); #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL ar_ptr_reset: got %b want 01", req_ready);
      end
      @(posedge clk); #2;
      req_valid = 2'b00;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      opr_a = '0;
      opr_b = '0;
      op_sel = {OP_ADD, OP_ADD};
      test_reset();
      test_single_add();
      test_two_requesters();
      test_backpressure();
      test_fairness();
      test_shifts_illegal();
      test_async_reset();
      @(negedge clk); #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d results never delivered, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
